// File: rtl/frame_rcvr_pkg.sv
// frame_rcvr_pkg: shared types and width helpers for the serial frame receiver.
//   state_e        : receiver FSM states (HUNT for the header, BODY for payload)
//   bit_cnt_w()    : width of the in-word bit counter
//   word_cnt_w()   : width of the in-frame word counter
//   level_w()      : width of a FIFO occupancy count (0..depth inclusive)
package frame_rcvr_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    BODY = 1'b1
  } state_e;

  // A counter always needs at least one bit, even when it only ever holds 0.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return clog2_min1(data_w);
  endfunction

  function automatic int word_cnt_w(input int frame_words);
    return clog2_min1(frame_words);
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/frame_rcvr_if.sv
// frame_rcvr_if: valid/ready output stream of the frame receiver.
//   out_valid : head word present
//   out_ready : consumer takes the head word this cycle
//   out_data  : head word
//   out_last  : head word closes its frame
// master = receiver side, slave = consumer side.
interface frame_rcvr_if #(
  parameter int DATA_W = 8
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rcvr_fifo.sv
// rcvr_fifo: synchronous FIFO between the deserialiser and the consumer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, push_data : write request and word
//   pop          : read request (ignored while empty)
//   pop_data     : head word (only meaningful while !empty)
//   full, empty, level : occupancy status, level in 0..DEPTH
// A push while full is accepted only if a real pop happens in the same cycle.
module rcvr_fifo
  import frame_rcvr_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // Same-cycle pop frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = mem[rd_ptr];
  assign level    = level_q;

  // Storage carries no reset: only occupancy decides what is visible.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

endmodule

// File: rtl/frame_rcvr.sv
// frame_rcvr: serial-bit frame receiver.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   data_in      : serial input, MSB first, sampled every clock
//   out_if       : valid/ready stream of payload words with a last-of-frame flag
//   overrun_clr  : clears the sticky overrun flag
//   overrun      : a completed word was dropped because the FIFO was full
//   fifo_level   : current FIFO occupancy
// Hunts for MATCH on the bit stream, then deserialises FRAME_WORDS words of
// DATA_W bits each and queues them in the output FIFO.
module frame_rcvr
  import frame_rcvr_pkg::*;
#(
  parameter int              HDR_W       = 8,
  parameter logic [HDR_W-1:0] MATCH      = 8'hA5,
  parameter int              DATA_W      = 8,
  parameter int              FRAME_WORDS = 4,
  parameter int              FIFO_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           data_in,
  frame_rcvr_if.master                   out_if,
  input  logic                           overrun_clr,
  output logic                           overrun,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int BIT_W  = bit_cnt_w(DATA_W);
  localparam int WORD_W = word_cnt_w(FRAME_WORDS);
  localparam int LVL_W  = level_w(FIFO_DEPTH);

  localparam logic [0:0] ST_HUNT = HUNT;
  localparam logic [0:0] ST_BODY = BODY;

  // Filling with the inverse of the header MSB means stale fill bits can
  // never complete a match on their own; a full header must arrive.
  localparam logic [HDR_W-2:0] HDR_FILL = {(HDR_W-1){~MATCH[HDR_W-1]}};

  logic [0:0]        state_q;
  logic [HDR_W-2:0]  hdr_q;
  logic [DATA_W-2:0] body_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0] word_cnt_q;
  logic              overrun_q;

  logic [HDR_W-1:0]  hdr_shift;
  logic [DATA_W-1:0] body_word;
  logic              hdr_hit;
  logic              word_done;
  logic              word_last;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              pop_fire;
  logic              word_drop;

  assign hdr_shift = {hdr_q, data_in};
  assign body_word = {body_q, data_in};
  assign hdr_hit   = (state_q == ST_HUNT) && (hdr_shift == MATCH);
  assign word_done = (state_q == ST_BODY) && (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign word_last = (word_cnt_q == WORD_W'(FRAME_WORDS - 1));

  assign pop_fire  = out_if.out_ready && !fifo_empty;
  assign word_drop = word_done && fifo_full && !pop_fire;

  // Hunt / body sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      hdr_q      <= HDR_FILL;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          hdr_q <= hdr_shift[HDR_W-2:0];
          if (hdr_hit) begin
            state_q    <= ST_BODY;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end
        end
        default: begin
          if (word_done) begin
            bit_cnt_q <= '0;
            if (word_last) begin
              state_q    <= ST_HUNT;
              hdr_q      <= HDR_FILL;
              word_cnt_q <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + WORD_W'(1);
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
      endcase
    end
  end

  // Payload shifter: free-running, only the BODY-state contents are consumed.
  always_ff @(posedge clock) begin
    body_q <= body_word[DATA_W-2:0];
  end

  // A drop wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (word_drop) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  rcvr_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (word_done),
    .push_data ({word_last, body_word}),
    .pop       (out_if.out_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Head is masked while empty so the outputs read zero after reset.
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_if.out_last  = fifo_empty ? 1'b0 : fifo_head[DATA_W];
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_frame_rcvr.sv
// tb_frame_rcvr: randomized and directed stimulus for frame_rcvr, checked by a
// queue scoreboard fed from a bit-stream/FIFO reference model.
module tb_frame_rcvr;

  localparam int             HDR_W       = 8;
  localparam logic [7:0]     MATCH       = 8'hA5;
  localparam int             DATA_W      = 8;
  localparam int             FRAME_WORDS = 4;
  localparam int             FIFO_DEPTH  = 4;
  localparam int             FILL        = MATCH[HDR_W-1] ? 0 : ((1 << (HDR_W - 1)) - 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       overrun;
  logic [2:0] fifo_level;

  frame_rcvr_if #(.DATA_W(DATA_W)) bus ();

  frame_rcvr #(
    .HDR_W       (HDR_W),
    .MATCH       (MATCH),
    .DATA_W      (DATA_W),
    .FRAME_WORDS (FRAME_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .out_if      (bus),
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
    .fifo_level  (fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  int    total = 0;
  int    bad   = 0;
  word_t sb_q[$];

  // Reference model state
  int m_level;
  bit m_ov;
  bit m_hunt;
  int m_hist;
  int m_nb;
  int m_nw;
  int m_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_ov    = 0;
    m_hunt  = 1;
    m_hist  = FILL;
    m_nb    = 0;
    m_nw    = 0;
    m_word  = 0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, advance the model, then check status after the edge.
  task automatic step(input bit din, input bit rdy, input bit clr);
    bit pop_m, done, last, push_ok;
    int w;
    data_in       = din;
    bus.out_ready = rdy;
    overrun_clr   = clr;
    pop_m = (m_level > 0) && rdy;
    done  = 0;
    last  = 0;
    w     = 0;
    if (m_hunt) begin
      m_hist = ((m_hist << 1) | int'(din)) & ((1 << HDR_W) - 1);
      if (m_hist == int'(MATCH)) begin
        m_hunt = 0;
        m_nb   = 0;
        m_nw   = 0;
        m_word = 0;
      end
    end else begin
      m_word = ((m_word << 1) | int'(din)) & ((1 << DATA_W) - 1);
      m_nb++;
      if (m_nb == DATA_W) begin
        done   = 1;
        w      = m_word;
        last   = (m_nw == FRAME_WORDS - 1);
        m_nw++;
        m_nb   = 0;
        m_word = 0;
        if (last) begin
          m_hunt = 1;
          m_hist = FILL;
        end
      end
    end
    push_ok = done && ((m_level < FIFO_DEPTH) || pop_m);
    if (push_ok) sb_q.push_back('{w[7:0], last});
    m_level = m_level + int'(push_ok) - int'(pop_m);
    if (done && !push_ok) m_ov = 1;
    else if (clr) m_ov = 0;
    @(posedge clock);
    #1;
    chk("fifo_level", fifo_level, m_level);
    chk("overrun", overrun, m_ov);
    chk("out_valid", bus.out_valid, m_level > 0);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    data_in       = 1'b0;
    bus.out_ready = 1'b0;
    overrun_clr   = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_level", fifo_level, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
  endtask

  // r drives ready for the first seven bits, rl/cl for the final bit.
  task automatic send_byte(input logic [7:0] b, input bit r, input bit rl, input bit cl);
    for (int i = 7; i >= 0; i--) begin
      step(b[i], (i == 0) ? rl : r, (i == 0) ? cl : 1'b0);
    end
  endtask

  task automatic send_frame(input logic [31:0] words, input bit r);
    send_byte(MATCH, r, r, 1'b0);
    for (int k = 3; k >= 0; k--) begin
      send_byte(words[k*8 +: 8], r, r, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_level > 0; i++) step(1'b0, 1'b1, 1'b0);
    chk("drain_level", fifo_level, 0);
  endtask

  // Scoreboard monitor: a pop happens where valid and ready meet at the edge.
  initial begin
    word_t e;
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0h with nothing expected", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          chk("pop_data", bus.out_data, e.data);
          chk("pop_last", bus.out_last, e.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    do_reset();

    // Basic frame, consumer always ready
    send_frame(32'h11223344, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("t1_overrun", overrun, 0);

    // Near-miss headers, then a real header and frame
    send_byte(8'hA4, 1'b1, 1'b1, 1'b0);
    send_byte(8'h25, 1'b1, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b1, 1'b0);
    chk("t2_no_push", bus.out_valid, 0);
    send_frame(32'h55667788, 1'b1);
    drain();

    // Header pattern inside payload, next frame immediately after
    send_frame(32'hA5A500FF, 1'b1);
    send_frame(32'h12345678, 1'b1);
    drain();

    // Back-to-back frames with no consumer
    send_frame(32'h11223344, 1'b0);
    send_frame(32'h55667788, 1'b0);
    chk("t4_level", fifo_level, 4);
    chk("t4_overrun", overrun, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_clr", overrun, 0);
    drain();

    // Full FIFO: pop on the push edge, then drop coinciding with clear
    send_frame(32'h11223344, 1'b0);
    send_byte(MATCH, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1, 1'b0);
    chk("t5_level", fifo_level, 4);
    chk("t5_overrun", overrun, 0);
    send_byte(8'h66, 1'b0, 1'b0, 1'b1);
    chk("t5_set_wins", overrun, 1);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    drain();

    // Reset in the middle of a frame
    send_byte(MATCH, 1'b0, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("t6_level", fifo_level, 2);
    do_reset();
    send_frame(32'hAABBCCDD, 1'b1);
    drain();

    // Random noise, frames, ready and clear
    for (int f = 0; f < 30; f++) begin
      int gap;
      logic [7:0] b;
      gap = $urandom_range(0, 6);
      for (int i = 0; i < gap; i++) begin
        step(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      end
      for (int k = 0; k < 5; k++) begin
        b = (k == 0) ? MATCH : 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          r = ($urandom_range(0, 2) != 0);
          step(b[i], r, ($urandom_range(0, 15) == 0));
        end
      end
    end
    drain();
    step(1'b0, 1'b0, 1'b1);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_rcvr.md
Name: frame_rcvr

Overview:
Serial-bit frame receiver. It hunts for a parametrised header pattern on a 1-bit input stream, then deserialises a fixed number of payload words. Completed words go into an internal FIFO, and a downstream consumer drains them through a valid/ready handshake. It is the multi-word, buffered, width-generic receiver used between serial links and the bus-side register logic.

Parameters:
HDR_W, 8, header width in bits (>=2)
MATCH, 8'hA5 (HDR_W bits), header pattern; MSB arrives first
DATA_W, 8, payload word width in bits (>=2)
FRAME_WORDS, 4, payload words per frame (>=1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
data_in  in  1  serial data, sampled every clock, MSB first
out_ready  in  1  consumer accepts head word this cycle
out_valid  out  1  FIFO non-empty
out_data  out  DATA_W  FIFO head word
out_last  out  1  head word is the final word of its frame
overrun_clr  in  1  clears the overrun flag
overrun  out  1  sticky: a completed word was dropped because the FIFO was full
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high, clock clock):
  - State becomes HUNT.
  - Header shift register (HDR_W-1 bits) is filled with ~MATCH[HDR_W-1].
  - Bit and word counters = 0; FIFO emptied.
  - Outputs: out_valid=0, out_last=0, out_data=0, overrun=0, fifo_level=0.
  - A partial frame in progress is discarded.
- State HUNT:
  - Each clock, data_in shifts left into the header register.
  - When {hdr_reg, data_in} == MATCH, the next state is BODY, with bit_cnt=0 and word_cnt=0.
  - The matching bit is not payload; the first payload bit is the next clock's data_in.
- State BODY:
  - data_in shifts left into body_reg; bit_cnt increments.
  - Header detection is disabled, so a MATCH pattern inside the payload is ignored.
  - When bit_cnt == DATA_W-1, the word {body_reg, data_in} is complete:
    - It is pushed with last = (word_cnt == FRAME_WORDS-1).
    - bit_cnt wraps to 0 and word_cnt increments.
  - After the last word's push, the state returns to HUNT and the header register is re-filled with ~MATCH[HDR_W-1].
  - Consequence: frames never overlap; the earliest next header bit is the clock after the last payload bit.
- Push latency:
  - The final bit of a word is sampled at edge N.
  - The word is written at edge N; out_valid/out_data reflect it after edge N if the FIFO was empty.
- Pop:
  - A pop occurs when out_valid && out_ready at an edge; the head advances.
  - out_ready while empty is ignored.
- Full FIFO:
  - A push while full and not popping in the same cycle drops the word and sets overrun.
  - Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, overrun is unchanged.
  - Push and pop in the same cycle while empty: the word is written, occupancy stays 0 at the next edge is NOT allowed. Occupancy must end at 1 (pop of an empty FIFO is ignored).
  - A dropped word does not abort the frame: reception continues, and later words are pushed if space frees up.
- overrun:
  - Cleared by overrun_clr at the next edge.
  - If a drop and overrun_clr occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.

Decomposition:
- Package frame_rcvr_pkg holds:
  - State enum {HUNT, BODY}.
  - Width helper functions for the counters (clog2(DATA_W), clog2(FRAME_WORDS), clog2(FIFO_DEPTH)+1).
- One sub-module, rcvr_fifo:
  - Synchronous FIFO, parametrised width (DATA_W+1, carrying last) and depth.
  - Provides push, pop, full, empty and level, with the simultaneous push/pop rules above.
- The hunt/deserialise FSM lives in frame_rcvr.

Test Plan (default parameters unless stated):
1. Serial 0xA5 then bytes 11,22,33,44 with out_ready=1 -> four pops 11,22,33,44; out_last=1 only on 44; overrun=0.
2. Near-miss headers 0xA4 and 0x25 followed by 0x11 -> no push, out_valid stays 0. Then bits 1010_0101 followed by a frame -> frame received.
3. Frame carrying A5,A5,00,FF -> exactly four words A5,A5,00,FF. No re-sync on payload A5; the next frame's header is detected right after FF.
4. out_ready=0, two back-to-back frames (11..44, 55..88) -> FIFO holds 11,22,33,44; 55..88 dropped; overrun=1, fifo_level=4. Pulse overrun_clr -> overrun=0.
5. FIFO full and out_ready=1 on the edge that pushes a new word -> word accepted, fifo_level stays 4, overrun stays 0. A drop coinciding with overrun_clr -> overrun=1.
6. Assert reset after 2 payload words and 3 bits -> FIFO empty, out_valid=0. The next full frame 0xA5,AA,BB,CC,DD is received correctly with out_last on DD.
